// File: rtl/tm_pred_ctrl.sv
// rtl/tm_pred_ctrl.sv - TrueMotion-style block predictor that streams one predicted row per handshake.
module tm_pred_ctrl #(
  parameter int  BIT_WIDTH  = 8,
  parameter int  BLOCK_SIZE = 16,
  localparam int IDX_W      = $clog2(BLOCK_SIZE),
  localparam int ROW_W      = BIT_WIDTH * BLOCK_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic                 top_avail,
  input  logic                 left_avail,
  input  logic [BIT_WIDTH-1:0] top_left,
  input  logic [ROW_W-1:0]     top,
  input  logic [ROW_W-1:0]     left,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [ROW_W-1:0]     row_data,
  output logic [IDX_W-1:0]     row_idx,
  output logic                 row_last,
  output logic [1:0]           mode,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [1:0] MODE_TM   = 2'd0;
  localparam logic [1:0] MODE_HOR  = 2'd1;
  localparam logic [1:0] MODE_VER  = 2'd2;
  localparam logic [1:0] MODE_FILL = 2'd3;

  state_t               state, state_next;
  logic [IDX_W-1:0]     row_cnt;
  logic [1:0]           mode_q;
  logic                 done_q;
  logic [BIT_WIDTH-1:0] tl_q;
  logic [ROW_W-1:0]     top_q;
  logic [ROW_W-1:0]     left_q;

  logic       accept;
  logic       is_last;
  logic       hs;
  logic [1:0] mode_dec;

  assign accept   = (state == IDLE) && start && !flush;
  assign is_last  = (row_cnt == IDX_W'(BLOCK_SIZE - 1));
  assign hs       = (state == EMIT) && row_ready;
  assign mode_dec = left_avail ? (top_avail ? MODE_TM : MODE_HOR)
                               : (top_avail ? MODE_VER : MODE_FILL);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = EMIT;
      EMIT: begin
        if (flush)              state_next = IDLE;
        else if (hs && is_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      mode_q  <= MODE_TM;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state == EMIT) && !flush && hs && is_last;
      if (accept) begin
        row_cnt <= '0;
        mode_q  <= mode_dec;
      end else if ((state == EMIT) && !flush && hs && !is_last) begin
        row_cnt <= row_cnt + 1'b1;
      end else if ((state == EMIT) && (state_next == IDLE)) begin
        row_cnt <= '0;
      end
    end
  end

  // Neighbour samples are plain data captures; the mode register alone gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      tl_q   <= top_left;
      top_q  <= top;
      left_q <= left;
    end
  end

  always_comb begin
    logic [BIT_WIDTH-1:0] left_j;
    logic [BIT_WIDTH-1:0] top_i;
    logic [BIT_WIDTH+1:0] sum;
    logic [BIT_WIDTH-1:0] tm_val;
    row_data = '0;
    left_j   = left_q[row_cnt*BIT_WIDTH +: BIT_WIDTH];
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      top_i = top_q[i*BIT_WIDTH +: BIT_WIDTH];
      // Two guard bits: the top bit flags a negative result, the next one an overflow.
      sum = {2'b00, top_i} + {2'b00, left_j} - {2'b00, tl_q};
      if (sum[BIT_WIDTH+1])    tm_val = '0;
      else if (sum[BIT_WIDTH]) tm_val = '1;
      else                     tm_val = sum[BIT_WIDTH-1:0];
      case (mode_q)
        MODE_TM:  row_data[i*BIT_WIDTH +: BIT_WIDTH] = tm_val;
        MODE_HOR: row_data[i*BIT_WIDTH +: BIT_WIDTH] = left_j;
        MODE_VER: row_data[i*BIT_WIDTH +: BIT_WIDTH] = top_i;
        default:  row_data[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(129);
      endcase
    end
  end

  assign row_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign row_idx   = row_cnt;
  assign row_last  = row_valid && is_last;
  assign mode      = mode_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tm_pred_ctrl.sv
// tb/tb_tm_pred_ctrl.sv - table-driven self-checking bench for tm_pred_ctrl.
module tb_tm_pred_ctrl;
  localparam int BW = 8;
  localparam int BS = 16;
  localparam int RW = BW * BS;

  logic          clk = 1'b0;
  logic          rst_n, start, flush, top_avail, left_avail, row_ready;
  logic [BW-1:0] top_left;
  logic [RW-1:0] top, left, row_data;
  logic          row_valid, row_last, busy, done;
  logic [3:0]    row_idx;
  logic [1:0]    mode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tm_pred_ctrl #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .top_avail(top_avail), .left_avail(left_avail), .top_left(top_left),
    .top(top), .left(left), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_idx(row_idx), .row_last(row_last),
    .mode(mode), .busy(busy), .done(done)
  );

  typedef struct {
    bit    top_ramp;
    bit    left_ramp;
    int    top_val;
    int    left_val;
    int    tl;
    bit    tav;
    bit    lav;
    int    exp_mode;
    string name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] exp_row(input vec_t v, input int j);
    logic [RW-1:0] r;
    int t, l, e;
    r = '0;
    for (int i = 0; i < BS; i++) begin
      t = v.top_val + (v.top_ramp ? i : 0);
      l = v.left_val + (v.left_ramp ? j : 0);
      case (v.exp_mode)
        0: begin
          e = t + l - v.tl;
          if (e < 0) e = 0;
          if (e > 255) e = 255;
        end
        1: e = l;
        2: e = t;
        default: e = 129;
      endcase
      r[i*BW +: BW] = BW'(e);
    end
    return r;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < BS; i++) begin
      top[i*BW +: BW]  = BW'(v.top_val + (v.top_ramp ? i : 0));
      left[i*BW +: BW] = BW'(v.left_val + (v.left_ramp ? i : 0));
    end
    top_left   = BW'(v.tl);
    top_avail  = v.tav;
    left_avail = v.lav;
  endtask

  task automatic scramble();
    top        = {$urandom, $urandom, $urandom, $urandom};
    left       = {$urandom, $urandom, $urandom, $urandom};
    top_left   = BW'($urandom);
    top_avail  = ~top_avail;
    left_avail = ~left_avail;
  endtask

  initial begin
    logic [RW-1:0] held;
    int hs_cnt, done_cnt, stall;

    vecs[0] = '{0, 0, 200, 100, 10, 1, 1, 0, "tm_clamp_hi"};
    vecs[1] = '{0, 0, 5,   5,   50, 1, 1, 0, "tm_clamp_lo"};
    vecs[2] = '{1, 1, 20,  30,  10, 1, 1, 0, "tm_ramp"};
    vecs[3] = '{0, 1, 77,  0,   0,  0, 1, 1, "hor"};
    vecs[4] = '{1, 0, 7,   99,  0,  1, 0, 2, "ver"};
    vecs[5] = '{0, 0, 33,  44,  55, 0, 0, 3, "fill"};
    vecs[6] = '{0, 0, 128, 127, 0,  1, 1, 0, "tm_255"};
    vecs[7] = '{0, 0, 128, 128, 0,  1, 1, 0, "tm_256"};
    vecs[8] = '{0, 0, 0,   0,   1,  1, 1, 0, "tm_neg1"};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; row_ready = 1'b1;
    load(vecs[0]);
    #1;
    chk("rst_valid", row_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_idx", row_idx, 0);     chk("rst_last", row_last, 0); chk("rst_mode", mode, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Streaming: every table entry with row_ready held high.
    for (int k = 0; k < 9; k++) begin
      load(vecs[k]);
      start = 1'b1;
      step();
      start = 1'b0;
      scramble();
      chk({vecs[k].name, "_mode"}, mode, vecs[k].exp_mode);
      chk({vecs[k].name, "_busy"}, busy, 1);
      for (int j = 0; j < BS; j++) begin
        chk({vecs[k].name, "_valid"}, row_valid, 1);
        chk({vecs[k].name, "_idx"}, row_idx, j);
        chk({vecs[k].name, "_last"}, row_last, (j == BS - 1));
        chk({vecs[k].name, "_data"}, row_data, exp_row(vecs[k], j));
        chk({vecs[k].name, "_nodone"}, done, 0);
        step();
      end
      chk({vecs[k].name, "_done"}, done, 1);
      chk({vecs[k].name, "_end_valid"}, row_valid, 0);
      step();
      chk({vecs[k].name, "_done_pulse"}, done, 0);
    end

    // Backpressure at row 5.
    load(vecs[3]);
    start = 1'b1;
    step();
    start = 1'b0;
    hs_cnt = 0; done_cnt = 0; stall = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      if (row_valid && row_idx == 4'd5 && stall < 3) begin
        if (stall == 0) begin
          held = row_data;
          chk("bp_first_data", row_data, exp_row(vecs[3], 5));
        end else begin
          chk("bp_idx", row_idx, 5);
          chk("bp_hold", row_data, held);
        end
        row_ready = 1'b0;
        stall++;
      end else begin
        row_ready = 1'b1;
      end
      if (row_valid && row_ready) hs_cnt++;
      if (done) done_cnt++;
      step();
    end
    row_ready = 1'b1;
    chk("bp_handshakes", hs_cnt, 16);
    chk("bp_done_count", done_cnt, 1);

    // Flush at row 7, flush also beating a same-cycle handshake.
    load(vecs[2]);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 7; j++) step();
    chk("fl_idx", row_idx, 7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", row_valid, 0);
    chk("fl_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      chk("fl_nodone", done, 0);
      chk("fl_novalid", row_valid, 0);
      step();
    end

    // flush together with start in IDLE blocks the start.
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("fs_busy", busy, 0);
    step();
    chk("fs_valid", row_valid, 0);

    // Start during EMIT is ignored; a start in the done cycle is accepted.
    load(vecs[3]);
    start = 1'b1;
    step();
    row_ready = 1'b0;
    load(vecs[5]);
    step();
    start = 1'b0;
    chk("se_mode", mode, 1);
    chk("se_idx", row_idx, 0);
    chk("se_data", row_data, exp_row(vecs[3], 0));
    row_ready = 1'b1;
    for (int j = 0; j < BS; j++) begin
      chk("se_row", row_data, exp_row(vecs[3], j));
      step();
    end
    chk("se_done", done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("dn_restart_busy", busy, 1);
    chk("dn_restart_mode", mode, 3);
    chk("dn_restart_data", row_data, exp_row(vecs[5], 0));
    done_cnt = 0;
    for (int c = 0; c < 40 && done_cnt == 0; c++) begin
      if (done) done_cnt++;
      else step();
    end
    chk("dn_restart_finish", done_cnt, 1);
    step();

    // Reset pulsed at row 3.
    load(vecs[0]);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("rm_idx", row_idx, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_valid", row_valid, 0); chk("rm_busy", busy, 0); chk("rm_done", done, 0);
    chk("rm_idx0", row_idx, 0);    chk("rm_last", row_last, 0); chk("rm_mode", mode, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rm_after_done", done, 0);
    chk("rm_after_valid", row_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tm_pred_ctrl.md
TM_PRED_CTRL -- requirements
Module: tm_pred_ctrl

Interface
REQ-001 Parameter BIT_WIDTH, default 8, SHALL set the sample width in bits.
REQ-002 Parameter BLOCK_SIZE, default 16, SHALL set the block edge in samples; legal values are 4, 8 and 16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request prediction of one block; sampled only in IDLE.
REQ-006 flush  input  1  SHALL be a synchronous abort of the block in progress.
REQ-007 top_avail / left_avail  input  1 each  SHALL flag whether top/left neighbours exist.
REQ-008 top_left  input  BIT_WIDTH  SHALL be the corner sample, captured on start.
REQ-009 top / left  input  BIT_WIDTH*BLOCK_SIZE each  SHALL be the neighbour rows, element i at bits [i*BIT_WIDTH +: BIT_WIDTH], captured on start.
REQ-010 row_valid  output  1  SHALL mark row_data as valid.
REQ-011 row_ready  input  1  SHALL be the downstream acceptance of the current row.
REQ-012 row_data  output  BIT_WIDTH*BLOCK_SIZE  SHALL carry the predicted row, column i at bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-013 row_idx  output  log2(BLOCK_SIZE)  SHALL carry the current row number j.
REQ-014 row_last  output  1  SHALL be high with row_valid when row_idx = BLOCK_SIZE-1.
REQ-015 mode  output  2  SHALL report the latched mode: 0 TM, 1 HOR, 2 VER, 3 FILL.
REQ-016 busy  output  1  SHALL be high in EMIT.
REQ-017 done  output  1  SHALL be a one-cycle pulse after the last row handshake.

Function
REQ-018 The FSM SHALL have exactly two states, IDLE and EMIT.
REQ-019 In IDLE with start=1 and flush=0, the block SHALL latch the inputs, avail flags and mode, clear the row counter and enter EMIT; start outside IDLE SHALL be ignored.
REQ-020 Mode SHALL be decoded at start as: left and top available -> TM; left only -> HOR; top only -> VER; neither -> FILL.
REQ-021 TM element (j,i) SHALL be clamp(top[i]+left[j]-top_left, 0, 2^BIT_WIDTH-1), computed in signed BIT_WIDTH+2 arithmetic.
REQ-022 HOR SHALL output left[j] in every column; VER SHALL output top[i] in every row; FILL SHALL output 129 in every element.
REQ-023 row_valid SHALL be high in EMIT, first asserted in the cycle after start is accepted (latency 1).
REQ-024 row_data, row_idx and row_last SHALL be derived only from latched registers and the row counter, and SHALL hold stable while row_valid=1 and row_ready=0.
REQ-025 A row handshake SHALL occur when row_valid=1 and row_ready=1; on a handshake the row counter SHALL increment, except on the last row.
REQ-026 A handshake on the last row SHALL return the FSM to IDLE and raise done for exactly the next cycle.
REQ-027 Rows SHALL stream back-to-back with no idle cycle while row_ready stays high: BLOCK_SIZE rows in BLOCK_SIZE cycles.
REQ-028 flush=1 in EMIT SHALL return the FSM to IDLE next cycle with no done pulse and no further row_valid.
REQ-029 flush SHALL take priority over a same-cycle handshake; flush together with start in IDLE SHALL prevent the start.
REQ-030 A new start SHALL be accepted no earlier than the cycle in which done is high.
REQ-031 Input changes after start is accepted SHALL NOT affect the block in progress.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE, and row_valid, busy, done, row_idx, row_last and mode SHALL be 0.
REQ-033 Reset asserted mid-block SHALL abandon the block immediately with no done pulse; the latched data registers need not be reset.

Verification
REQ-034 TM clamp: top all 200, left all 100, top_left 10, both avail -> every element 255; top all 5, left all 5, top_left 50 -> every element 0.
REQ-035 Mode decode: left only, left[j]=j -> mode 1, row j all j; top only -> mode 2; neither -> mode 3, all elements 129.
REQ-036 Backpressure: row_ready low for 3 cycles at row 5 -> row_idx 5 and row_data held stable; 16 total handshakes, then a single done.
REQ-037 Streaming: row_ready held high -> row_valid for 16 consecutive cycles starting 1 cycle after start; done on the cycle after row_last.
REQ-038 Abort: flush at row 7 -> IDLE, no done; rst_n pulsed low at row 3 -> all outputs 0 immediately; start during EMIT is ignored.
